// File: rtl/cond_unit_if.sv
// cond_unit_if: connects the execute-stage decoder/ALU to the conditional-execution
// unit.
//   Pipeline -> unit : en, valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
//                      save, restore
//   Unit -> pipeline : CondEx, PCSrc, RegWrite, MemWrite, Flags, SavedFlags, FailCount
// The master modport is the pipeline side. The slave modport is the cond_unit side.
interface cond_unit_if #(
  parameter int CNTW = 16
);
  logic            en;
  logic            valid;
  logic [3:0]      Cond;
  logic [3:0]      ALUFlags;
  logic [1:0]      FlagW;
  logic            PCS;
  logic            RegW;
  logic            MemW;
  logic            NoWrite;
  logic            save;
  logic            restore;
  logic            CondEx;
  logic            PCSrc;
  logic            RegWrite;
  logic            MemWrite;
  logic [3:0]      Flags;
  logic [3:0]      SavedFlags;
  logic [CNTW-1:0] FailCount;

  modport master (
    output en, valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, save, restore,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags, SavedFlags, FailCount
  );

  modport slave (
    input  en, valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, save, restore,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags, SavedFlags, FailCount
  );
endinterface

// File: rtl/cond_unit.sv
// cond_unit: ARMv4 execute-stage conditional-execution unit.
// The unit holds the architectural NZCV flags. It decodes each instruction's condition
// field against those flags and gates the PC, register and memory write controls. The
// flags are updated from the ALU only when the instruction executes. The unit also
// keeps a saved-flags copy for exception entry and return. A saturating counter
// records condition-failed instructions.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - cond_unit_if.slave: stage controls in, gated controls and state out
// The control outputs are combinational. Flags, SavedFlags and FailCount are registered.
module cond_unit #(
  parameter int CNTW = 16
) (
  input logic         clk,
  input logic         rst_n,
  cond_unit_if.slave  bus
);

  logic [3:0]      flags_r;
  logic [3:0]      saved_flags_r;
  logic [CNTW-1:0] fail_cnt_r;
  logic            decode_s;
  logic            cond_ex_s;
  logic            flag_n_s;
  logic            flag_z_s;
  logic            flag_c_s;
  logic            flag_v_s;

  assign flag_n_s = flags_r[3];
  assign flag_z_s = flags_r[2];
  assign flag_c_s = flags_r[1];
  assign flag_v_s = flags_r[0];

  // Decode the condition field against the registered flags. ALUFlags has no bypass.
  always_comb begin
    decode_s = 1'b0;
    case (bus.Cond)
      4'b0000: decode_s = flag_z_s;
      4'b0001: decode_s = ~flag_z_s;
      4'b0010: decode_s = flag_c_s;
      4'b0011: decode_s = ~flag_c_s;
      4'b0100: decode_s = flag_n_s;
      4'b0101: decode_s = ~flag_n_s;
      4'b0110: decode_s = flag_v_s;
      4'b0111: decode_s = ~flag_v_s;
      4'b1000: decode_s = flag_c_s & ~flag_z_s;
      4'b1001: decode_s = ~flag_c_s | flag_z_s;
      4'b1010: decode_s = (flag_n_s == flag_v_s);
      4'b1011: decode_s = (flag_n_s != flag_v_s);
      4'b1100: decode_s = ~flag_z_s & (flag_n_s == flag_v_s);
      4'b1101: decode_s = flag_z_s | (flag_n_s != flag_v_s);
      4'b1110: decode_s = 1'b1;
      4'b1111: decode_s = 1'b0;
      default: decode_s = 1'b0;
    endcase
  end

  // Bubbles and reset never execute. Stall (en) is left to the consumer of these outputs.
  assign cond_ex_s    = decode_s & bus.valid & rst_n;
  assign bus.CondEx   = cond_ex_s;
  assign bus.PCSrc    = bus.PCS & cond_ex_s;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & cond_ex_s;
  assign bus.MemWrite = bus.MemW & cond_ex_s;

  assign bus.Flags      = flags_r;
  assign bus.SavedFlags = saved_flags_r;
  assign bus.FailCount  = fail_cnt_r;

  // Architectural flags: restore beats the ALU write. The NZ and CV halves are written
  // independently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (bus.en) begin
      if (bus.restore) begin
        flags_r <= saved_flags_r;
      end else begin
        if (cond_ex_s && bus.FlagW[1]) begin
          flags_r[3:2] <= bus.ALUFlags[3:2];
        end
        if (cond_ex_s && bus.FlagW[0]) begin
          flags_r[1:0] <= bus.ALUFlags[1:0];
        end
      end
    end else begin
      flags_r <= flags_r;
    end
  end

  // Saved flags capture the pre-edge Flags. Save together with restore therefore swaps
  // the two registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      saved_flags_r <= 4'b0000;
    end else if (bus.en && bus.save) begin
      saved_flags_r <= flags_r;
    end else begin
      saved_flags_r <= saved_flags_r;
    end
  end

  // Count condition-failed real instructions. The counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_cnt_r <= {CNTW{1'b0}};
    end else if (bus.en && bus.valid && !decode_s && (fail_cnt_r != {CNTW{1'b1}})) begin
      fail_cnt_r <= fail_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      fail_cnt_r <= fail_cnt_r;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard bench for cond_unit. The driver computes expectations from a
// behavioural model and queues them. A monitor on the falling edge pops them and
// compares them against the DUT.
module tb_cond_unit;

  localparam int CNTW = 16;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk;
  logic rst_n;

  cond_unit_if #(.CNTW(CNTW)) bus();

  cond_unit #(.CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        condex;
    logic        pcsrc;
    logic        regwrite;
    logic        memwrite;
    logic [3:0]  flags;
    logic [3:0]  saved;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // reference architectural state
  logic [3:0] m_flags;
  logic [3:0] m_saved;
  int         m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // condition rule: odd codes are the negation of the preceding even code (AL/NV too)
  function automatic bit ref_pass(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare one queued expectation per cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("CondEx",     {15'd0, bus.CondEx},   {15'd0, e.condex});
        chk("PCSrc",      {15'd0, bus.PCSrc},    {15'd0, e.pcsrc});
        chk("RegWrite",   {15'd0, bus.RegWrite}, {15'd0, e.regwrite});
        chk("MemWrite",   {15'd0, bus.MemWrite}, {15'd0, e.memwrite});
        chk("Flags",      {12'd0, bus.Flags},      {12'd0, e.flags});
        chk("SavedFlags", {12'd0, bus.SavedFlags}, {12'd0, e.saved});
        chk("FailCount",  bus.FailCount,           e.cnt);
      end
    end
  end

  // drive one cycle: apply inputs, queue expectations, then advance the model at the edge
  task automatic step(input bit r, input bit e, input bit v, input logic [3:0] c,
                      input logic [3:0] alu, input logic [1:0] fw, input bit pcs,
                      input bit rw, input bit mw, input bit nw, input bit sv, input bit rs);
    exp_t x;
    bit   pass;
    logic [3:0] nf;
    rst_n = r; bus.en = e; bus.valid = v; bus.Cond = c; bus.ALUFlags = alu;
    bus.FlagW = fw; bus.PCS = pcs; bus.RegW = rw; bus.MemW = mw; bus.NoWrite = nw;
    bus.save = sv; bus.restore = rs;
    pass       = r && v && ref_pass(m_flags, c);
    x.condex   = pass;
    x.pcsrc    = pass && pcs;
    x.regwrite = pass && rw && !nw;
    x.memwrite = pass && mw;
    x.flags    = m_flags;
    x.saved    = m_saved;
    x.cnt      = m_cnt[15:0];
    q.push_back(x);
    @(posedge clk);
    if (!r) begin
      m_flags = 4'b0000; m_saved = 4'b0000; m_cnt = 0;
    end else if (e) begin
      nf = m_flags;
      if (rs) nf = m_saved;
      else begin
        if (pass && fw[1]) nf[3:2] = alu[3:2];
        if (pass && fw[0]) nf[1:0] = alu[1:0];
      end
      if (sv) m_saved = m_flags;
      if (v && !ref_pass(m_flags, c)) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_flags = nf;
    end
    #1;
  endtask

  // load the flags through an AL flag-setting instruction
  task automatic load_flags(input logic [3:0] f);
    step(1, 1, 1, 4'hE, f, 2'b11, 0, 0, 0, 0, 0, 0);
  endtask

  // watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_flags = 4'b0000; m_saved = 4'b0000; m_cnt = 0;
    rst_n = 1'b0; bus.en = 1'b0; bus.valid = 1'b0; bus.Cond = 4'h0; bus.ALUFlags = 4'h0;
    bus.FlagW = 2'b00; bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
    bus.NoWrite = 1'b0; bus.save = 1'b0; bus.restore = 1'b0;
    @(posedge clk); #1;
    // reset with an AL register write pending
    repeat (2) step(0, 1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    // condition sweep with Z=1, C=1
    load_flags(4'b0110);
    for (int c = 0; c < 16; c++) step(1, 1, 1, c[3:0], 4'h0, 2'b00, 1, 1, 1, 0, 0, 0);
    // failed flag-setting write
    load_flags(4'b0100);
    step(1, 1, 1, 4'h1, 4'b1001, 2'b11, 1, 1, 1, 0, 0, 0);
    // partial CV write, then a compare-type instruction
    load_flags(4'b1111);
    step(1, 1, 1, 4'hE, 4'b0000, 2'b01, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 1, 0, 0);
    // save, restore, swap
    load_flags(4'b1010);
    step(1, 1, 1, 4'hE, 4'b0101, 2'b11, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0, 1, 1);
    // stall with everything asserted
    step(1, 0, 1, 4'hF, 4'b1111, 2'b11, 1, 1, 1, 0, 1, 1);
    step(1, 0, 1, 4'h0, 4'b0000, 2'b11, 1, 1, 1, 0, 1, 1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 1),
           4'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end
    // counter saturation: fill to 0xFFFE, then three more failures
    step(0, 1, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    while (m_cnt < CMAX - 1) step(1, 1, 1, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 1, 4'hF, 4'h0, 2'b00, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
